// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave endpoint.
package spi_pkg;

  localparam int unsigned SPI_DATA_W   = 8;
  localparam logic [7:0]  SPI_IDLE_TX  = 8'hFF;

  // Mode bit positions in the master's control word
  localparam int unsigned SPI_CPHA_BIT = 0;
  localparam int unsigned SPI_CPOL_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic spi_mode_t spi_mode_from_ctrl(input logic [1:0] ctrl);
    spi_mode_t m;
    m.cpol = ctrl[SPI_CPOL_BIT];
    m.cpha = ctrl[SPI_CPHA_BIT];
    return m;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer followed by one history flop for rise/fall detection.
module spi_edge_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = STAGES'({sync_q, d});
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level  = sync_q[STAGES-1];
  assign rise_c = level & ~prev_q;
  assign fall_c = ~level & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// Oversampled single-byte SPI slave with valid/ack parallel side, all four modes.
// Define SPI_SLAVE_RXFIFO_EN to turn the receive register into an RXFIFO_DEPTH-entry FIFO.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W       = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned RXFIFO_DEPTH = 4
) (
  input  logic              pro_clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int unsigned RX_DEPTH = RXFIFO_DEPTH;
`else
  // Single holding register; the FIFO depth only matters in the FIFO build
  localparam int unsigned RX_DEPTH = 1 + 0 * RXFIFO_DEPTH;
`endif
  localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH + 1);

  // Synchronized serial inputs
  logic sclk_level, sclk_rise_c, sclk_fall_c;
  logic ss_level, ss_rise_c, ss_fall_c;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic mosi_s;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (pro_clk),
    .rst_n  (rst_n),
    .d      (sclk),
    .level  (sclk_level),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk    (pro_clk),
    .rst_n  (rst_n),
    .d      (ss_n),
    .level  (ss_level),
    .rise_c (ss_rise_c),
    .fall_c (ss_fall_c)
  );

  assign mosi_sync_d = SYNC_STAGES'({mosi_sync_q, mosi});
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  // Frame state
  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
  logic              first_q, first_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              miso_en_q, miso_en_d;

  // Parallel-side buffers
  logic [DATA_W-1:0]   tx_buf_q, tx_buf_d;
  logic                tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0]   rx_mem_q [RX_DEPTH];
  logic [DATA_W-1:0]   rx_mem_d [RX_DEPTH];
  logic [RX_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic                rx_valid_q, rx_valid_d;
  logic                overrun_q, overrun_d;
  logic                rx_pop_c;

  // Leading/trailing classified by the level reached relative to the latched CPOL
  logic sclk_any_c, lead_c, trail_c, sample_c, shift_c;
  assign sclk_any_c = sclk_rise_c | sclk_fall_c;
  assign lead_c     = sclk_any_c & (sclk_level != mode_q.cpol);
  assign trail_c    = sclk_any_c & (sclk_level == mode_q.cpol);
  assign sample_c   = mode_q.cpha ? trail_c : lead_c;
  assign shift_c    = mode_q.cpha ? (lead_c & ~first_q) : trail_c;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    first_d    = first_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_c) begin
          state_d    = ST_SHIFT;
          mode_d     = spi_mode_from_ctrl({cpol, cpha});
          tx_shift_d = tx_ready_q ? DATA_W'(SPI_IDLE_TX) : tx_buf_q;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          first_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ss_rise_c) begin
          state_d = ST_IDLE;
        end else begin
          if (lead_c) first_d = 1'b0;
          if (shift_c) tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          if (sample_c) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d   = ST_DONE;
              done_d    = 1'b1;
              rx_byte_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        if (ss_rise_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d    = (state_d != ST_IDLE);
    miso_en_d = ~ss_level;
  end

  // Buffer updates one cycle after the frame's final sample
  always_comb begin
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    rx_mem_d   = rx_mem_q;
    rx_cnt_d   = rx_cnt_q;
    overrun_d  = overrun_q;
    rx_pop_c   = rx_ack & rx_valid_q;

    if (rx_pop_c) begin
      for (int i = 0; i + 1 < int'(RX_DEPTH); i++) rx_mem_d[i] = rx_mem_q[i+1];
      rx_cnt_d = rx_cnt_q - RX_CNT_W'(1);
    end

    if (rx_ack) overrun_d = 1'b0;

    if (done_q) begin
      if (rx_cnt_d < RX_CNT_W'(RX_DEPTH)) begin
        for (int i = 0; i < int'(RX_DEPTH); i++) begin
          if (RX_CNT_W'(i) == rx_cnt_d) rx_mem_d[i] = rx_byte_q;
        end
        rx_cnt_d = rx_cnt_d + RX_CNT_W'(1);
      end else begin
        overrun_d = 1'b1;
      end
      tx_ready_d = 1'b1;
    end

    // Sees the pre-completion tx_ready_q, so a load racing completion is dropped
    if (tx_load && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end

    rx_valid_d = (rx_cnt_d != '0);
  end

  always_ff @(posedge pro_clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      miso_en_q   <= 1'b0;
      tx_buf_q    <= '0;
      tx_ready_q  <= 1'b1;
      rx_mem_q    <= '{default: '0};
      rx_cnt_q    <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      first_q     <= first_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      miso_en_q   <= miso_en_d;
      tx_buf_q    <= tx_buf_d;
      tx_ready_q  <= tx_ready_d;
      rx_mem_q    <= rx_mem_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign miso     = miso_en_q ? tx_shift_q[DATA_W-1] : 1'bz;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_mem_q[0];
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Self-checking bench for spi_slave_port: a bit-banged SPI master plus a queue-based buffer model.
module tb_spi_slave_port;

  localparam int HP = 8;
`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       pro_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       sclk    = 1'b0;
  logic       ss_n    = 1'b1;
  logic       mosi    = 1'b0;
  logic       cpol    = 1'b0;
  logic       cpha    = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       rx_ack  = 1'b0;
  wire        miso;
  logic       tx_ready, rx_valid, overrun, busy;
  logic [7:0] rx_data;

  always #5 pro_clk = ~pro_clk;

  spi_slave_port #(.DATA_W(8), .SYNC_STAGES(2), .RXFIFO_DEPTH(4)) dut (
    .pro_clk  (pro_clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .cpol     (cpol),
    .cpha     (cpha),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .overrun  (overrun),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: transmit holding slot and receive queue
  logic [7:0] rxq[$];
  bit         m_full = 1'b0;
  logic [7:0] m_tx   = 8'h00;
  bit         m_ovr  = 1'b0;

  typedef struct {
    bit         cp;
    bit         ch;
    bit         ld;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pro_clk);
  endtask

  task automatic do_load(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_tx   = b;
    end
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    if (rxq.size() > 0) void'(rxq.pop_front());
    m_ovr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] zexp;
    zexp = {31'b0, 1'bz};
    check({tag, "_rx_valid"}, {31'b0, rx_valid}, {31'b0, rxq.size() != 0});
    if (rxq.size() != 0) check({tag, "_rx_data"}, {24'b0, rx_data}, {24'b0, rxq[0]});
    check({tag, "_tx_ready"}, {31'b0, tx_ready}, {31'b0, !m_full});
    check({tag, "_overrun"}, {31'b0, overrun}, {31'b0, m_ovr});
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_miso_z"}, {31'b0, miso}, zexp);
  endtask

  // Master side of one frame; samples miso at the master's own sample edges
  task automatic frame(input bit cp, input bit ch, input logic [7:0] mo, input int nbits,
                       input bit keep_ss, output logic [7:0] mi);
    bit chk_rise;
    bit last;
    chk_rise = (nbits == 8) && (rxq.size() == 0);
    mi   = 8'h00;
    cpol = cp;
    cpha = ch;
    sclk = cp;
    tick(HP);
    ss_n = 1'b0;
    mosi = mo[7];
    tick(2);
    check("busy_before_latency", {31'b0, busy}, 32'd0);
    tick(1);
    check("busy_after_latency", {31'b0, busy}, 32'd1);
    tick(HP - 3);
    for (int i = 0; i < nbits; i++) begin
      last = (i == nbits - 1);
      if (!ch) begin
        mi[7-i] = miso;
        sclk = ~cp;
      end else begin
        sclk = ~cp;
        mosi = mo[7-i];
        tick(HP);
        mi[7-i] = miso;
        sclk = cp;
      end
      if (last && chk_rise) begin
        tick(3);
        check("rx_valid_not_early", {31'b0, rx_valid}, 32'd0);
        tick(1);
        check("rx_valid_latency", {31'b0, rx_valid}, 32'd1);
        check("tx_ready_with_rx_valid", {31'b0, tx_ready}, 32'd1);
        tick(HP - 4);
      end else begin
        tick(HP);
      end
      if (!ch) begin
        sclk = cp;
        if (i < 7) mosi = mo[6-i];
        tick(HP);
      end
    end
    if (!keep_ss) begin
      ss_n = 1'b1;
      tick(6);
    end
  endtask

  task automatic do_frame(input bit cp, input bit ch, input logic [7:0] mo, input int nbits,
                          output logic [7:0] mi);
    logic [7:0] exp;
    exp = m_full ? m_tx : 8'hFF;
    frame(cp, ch, mo, nbits, 1'b0, mi);
    check("master_rx_bits", {24'b0, mi >> (8 - nbits)}, {24'b0, exp >> (8 - nbits)});
    if (nbits == 8) begin
      if (rxq.size() < DEPTH) rxq.push_back(mo);
      else m_ovr = 1'b1;
      m_full = 1'b0;
    end
    check_state("post_frame");
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] b;
    logic [31:0] zexp;
    int nb;
    zexp = {31'b0, 1'bz};

    vecs[0] = '{cp: 1'b0, ch: 1'b0, ld: 1'b1, tx: 8'hA5, mo: 8'h3C, exp_mi: 8'hA5, exp_rx: 8'h3C};
    vecs[1] = '{cp: 1'b0, ch: 1'b1, ld: 1'b1, tx: 8'h81, mo: 8'h7E, exp_mi: 8'h81, exp_rx: 8'h7E};
    vecs[2] = '{cp: 1'b1, ch: 1'b0, ld: 1'b1, tx: 8'h5A, mo: 8'hC3, exp_mi: 8'h5A, exp_rx: 8'hC3};
    vecs[3] = '{cp: 1'b1, ch: 1'b1, ld: 1'b1, tx: 8'h0F, mo: 8'hF0, exp_mi: 8'h0F, exp_rx: 8'hF0};
    vecs[4] = '{cp: 1'b0, ch: 1'b0, ld: 1'b0, tx: 8'h00, mo: 8'h55, exp_mi: 8'hFF, exp_rx: 8'h55};

    // Reset values
    tick(3);
    check("rst_miso", {31'b0, miso}, zexp);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_rx_data", {24'b0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Directed per-mode vectors
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].ld) do_load(vecs[v].tx);
      check("tbl_tx_ready_pre", {31'b0, tx_ready}, {31'b0, !vecs[v].ld});
      do_frame(vecs[v].cp, vecs[v].ch, vecs[v].mo, 8, mi);
      check("tbl_master_rx", {24'b0, mi}, {24'b0, vecs[v].exp_mi});
      check("tbl_rx_data", {24'b0, rx_data}, {24'b0, vecs[v].exp_rx});
      check("tbl_rx_valid", {31'b0, rx_valid}, 32'd1);
      do_ack();
      tick(1);
      check("tbl_rx_valid_popped", {31'b0, rx_valid}, 32'd0);
    end

    // Abort after 4 bits keeps the tx byte for the next frame
    do_load(8'hC6);
    do_frame(1'b0, 1'b0, 8'h9A, 4, mi);
    check("abort_tx_ready", {31'b0, tx_ready}, 32'd0);
    check("abort_rx_valid", {31'b0, rx_valid}, 32'd0);
    do_frame(1'b0, 1'b0, 8'h33, 8, mi);
    check("abort_resend", {24'b0, mi}, 32'hC6);
    do_ack();
    tick(1);

    // Fill the receive buffer past capacity, then drain it
    for (int k = 1; k <= DEPTH + 1; k++) begin
      do_frame(1'b0, 1'b0, 8'(17 * k), 8, mi);
      check("ovr_flag", {31'b0, overrun}, {31'b0, k == DEPTH + 1});
      check("ovr_head", {24'b0, rx_data}, 32'h11);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      check("ovr_pop_data", {24'b0, rx_data}, {24'b0, 8'(17 * k)});
      do_ack();
      tick(1);
      check("ovr_cleared", {31'b0, overrun}, 32'd0);
    end
    check_state("drained");

    // Reset in the middle of a frame
    do_load(8'h77);
    frame(1'b0, 1'b0, 8'hE1, 3, 1'b1, mi);
    rst_n = 1'b0;
    #1;
    check("midrst_miso", {31'b0, miso}, zexp);
    check("midrst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("midrst_rx_data", {24'b0, rx_data}, 32'd0);
    check("midrst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("midrst_overrun", {31'b0, overrun}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    rxq.delete();
    m_full = 1'b0;
    m_ovr  = 1'b0;
    tick(1);
    ss_n = 1'b1;
    sclk = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    do_frame(1'b0, 1'b0, 8'h4B, 8, mi);
    check("midrst_next_rx", {24'b0, rx_data}, 32'h4B);
    do_ack();
    tick(1);

    // Randomized frames against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        b = 8'($urandom);
        do_load(b);
      end
      nb = ($urandom_range(4, 0) == 0) ? int'($urandom_range(7, 1)) : 8;
      b = 8'($urandom);
      do_frame(1'($urandom), 1'($urandom), b, nb, mi);
      if ($urandom_range(9, 0) < 7) begin
        do_ack();
        tick(1);
        check_state("rand_ack");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

Single-byte SPI slave endpoint that sits directly downstream of `SPI_Master`: it consumes `sclk`, `mosi` and one `ss` line and returns `miso`. It oversamples the serial interface with the system clock and supports all four CPOL/CPHA modes. It presents received bytes and accepts transmit bytes through a simple valid/ack parallel interface to local logic. One byte is transferred per slave-select assertion, matching the master's frame format.

## Interface
- `DATA_W`, 8, frame width in bits; transfers are MSB first.
- `SYNC_STAGES`, 2, synchronizer depth on `sclk`, `ss_n` and `mosi`.
- `RXFIFO_DEPTH`, 4, receive FIFO depth; used only when `SPI_SLAVE_RXFIFO_EN` is defined.

Ports:
- `pro_clk` in 1: system clock; one clock domain only.
- `rst_n` in 1: reset, asynchronous and active-low.
- `sclk` in 1: serial clock from the master.
- `ss_n` in 1: active-low select, wired to one bit of the master's `ss` bus.
- `mosi` in 1: serial data from the master.
- `miso` out 1: serial data to the master; `1'bz` while deselected.
- `cpol`, `cpha` in 1 each: SPI mode; latched on the synchronized `ss_n` fall.
- `tx_data` in DATA_W: byte to transmit.
- `tx_load` in 1: write strobe for `tx_data`.
- `tx_ready` out 1: transmit buffer empty.
- `rx_data` out DATA_W: oldest received byte.
- `rx_valid` out 1: `rx_data` holds an unread byte.
- `rx_ack` in 1: consumes `rx_data`.
- `overrun` out 1: sticky flag; a byte was dropped.
- `busy` out 1: a frame is in progress.

## Operation
- `sclk`, `ss_n` and `mosi` each pass through SYNC_STAGES flops, followed by one edge-detect flop.
- Edge definitions:
  - Leading edge: rising when CPOL=0, falling when CPOL=1.
  - Trailing edge: the opposite transition.
- State machine:
  - IDLE: on `ss_n` falling edge, latch mode, load tx_shift, clear bit_cnt and go to SHIFT.
  - SHIFT: transfer bits as below; after 8 samples go to DONE.
  - DONE: ignore `sclk` edges until `ss_n` rises, then return to IDLE.
  - `ss_n` rising in SHIFT: abort and return to IDLE.
- tx_shift source at frame start:
  - Transmit buffer contents if the buffer is full; the buffer stays full during the frame.
  - `8'hFF` if the buffer is empty.
- `miso` = tx_shift[7] whenever `ss_n` is low.
- CPHA=0 bit transfer:
  - Sample `mosi` on the leading edge.
  - Shift tx_shift on the trailing edge.
- CPHA=1 bit transfer:
  - Shift on every leading edge except the first of the frame.
  - Sample on the trailing edge.
- bit_cnt counts samples 0..7. The 8th sample completes the frame:
  - The received byte is pushed to the receive buffer.
  - The transmit buffer is marked empty.
- Abort (`ss_n` rises before the 8th sample):
  - Partial rx bits are discarded.
  - No `rx_valid` is produced.
  - The transmit buffer is not consumed, so the same byte is resent next frame.
- Transmit buffer writes:
  - `tx_load` is accepted only when `tx_ready`=1 in that cycle; otherwise it is ignored.
  - Frame completion and `tx_load` in the same cycle: the load is ignored, because `tx_ready` was 0.
- Receive buffer:
  - Holds one byte by default.
  - `rx_ack` while `rx_valid`=1 pops the byte.
  - A push while full drops the new byte, keeps the old byte and sets `overrun`.
  - A push and `rx_ack` in the same cycle: pop then push; `rx_valid` stays 1 and there is no overrun.
  - `overrun` clears on any cycle with `rx_ack`=1.
- `busy` = 1 in SHIFT and DONE.

## Timing
- Reset values:
  - `miso` = Z, `tx_ready` = 1, `rx_data` = 0, `rx_valid` = 0, `overrun` = 0, `busy` = 0.
  - FSM in IDLE, all shift registers and counters cleared.
- `rst_n` asserted mid-frame: outputs return to reset values immediately, and the frame is lost.
- Every `sclk` half-period must be at least SYNC_STAGES+2 `pro_clk` cycles; faster `sclk` is unsupported.
- `miso` changes at most SYNC_STAGES+2 cycles after the real shift edge, satisfying the master's setup before its sample edge.
- `rx_valid` rises SYNC_STAGES+2 cycles after the real 8th sample edge.
- `tx_ready` rises in the same cycle as `rx_valid`.
- `busy` rises SYNC_STAGES+1 cycles after the `ss_n` fall.

## Configuration
- `SPI_SLAVE_RXFIFO_EN` defined:
  - The receive buffer is an RXFIFO_DEPTH-entry FIFO; `rx_data` shows the head entry.
  - `rx_valid` = not empty.
  - `overrun` sets on a push while full, and the new byte is dropped.
- `SPI_SLAVE_RXFIFO_EN` undefined: the receive buffer is a single register with the identical rules at depth 1.

## Structure
- Package `spi_pkg`:
  - FSM state enum (IDLE, SHIFT, DONE).
  - `SPI_IDLE_TX` = `8'hFF`.
  - Default DATA_W.
  - Mode bit positions CPOL/CPHA, shared with `SPI_Master`'s control word.
- Sub-module `spi_edge_sync`: synchronizer plus rise/fall detect, instantiated for `sclk` and `ss_n`; `mosi` uses the synchronizer only.

## Test plan
- Mode 0: `tx_load` `0xA5`, master sends `0x3C` with 8-cycle half-period → `miso` shows 1,0,1,0,0,1,0,1; `rx_data`=`0x3C`, `rx_valid`=1, `tx_ready`=1.
- Modes 1, 2, 3: tx `0x81`/`0x5A`/`0x0F`, rx `0x7E`/`0xC3`/`0xF0` → bits match at the master's sample edges; `rx_data` is correct in each mode.
- Abort: `ss_n` rises after 4 bits → no `rx_valid`, `tx_ready` stays 0, `busy`=0; the next full frame resends the original tx byte.
- Empty transmit buffer: frame with `tx_ready`=1 → master receives `0xFF`.
- Overrun: two frames (`0x11`, `0x22`) without ack → `overrun`=1 and `rx_data`=`0x11`. With the macro defined, five frames → `overrun` only after the 5th, and four pops read `0x11`..`0x44`.
- Reset after 3 bits: `rst_n` low → all outputs at reset values and `miso`=Z; the next frame completes normally.
